// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle control sequencer: states, opcodes,
// datapath mux select values and the bundled control-output record.
package mc_ctrl_pkg;

    localparam int OP_W    = 6;
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    // Every datapath control decoded from the current state, kept in one
    // record so a single '0 clears them all.
    typedef struct packed {
        logic    pc_write;
        logic    branch;
        logic    ir_write;
        logic    iord;
        logic    mem_read;
        logic    mem_write;
        logic    reg_dst;
        logic    mem_to_reg;
        logic    reg_write;
        logic    alu_src_a;
        src_b_t  alu_src_b;
        alu_op_t alu_op;
        pc_src_t pc_src;
        logic    instr_done;
        logic    illegal_op;
        logic    mem_timeout;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the sequencer (master) and the datapath/memory side
// (slave). The zero flag travels with the bus for the datapath's branch logic.
interface multicycle_control_fsm_if
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = OP_W
);
    logic [OPW-1:0]     opcode;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic               branch;
    logic               ir_write;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_src;
    logic [STATE_W-1:0] state;
    logic               instr_done;
    logic               illegal_op;
    logic               mem_timeout;

    modport master (
        input  opcode, mem_ready,
        output pc_write, branch, ir_write, iord, mem_read, mem_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, state, instr_done, illegal_op, mem_timeout
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, branch, ir_write, iord, mem_read, mem_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, state, instr_done, illegal_op, mem_timeout
    );

endinterface

// File: rtl/multicycle_control_fsm_watchdog.sv
// Counts consecutive not-ready cycles in a memory-access state and flags an
// abort once the count reaches MEM_TIMEOUT. The sequencer only leaves such a
// state on ready or on this abort, so clearing on either also covers every
// state change.
module mem_wait_watchdog #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Timeout compare and next count: advance only while stalled short of the limit.
    always_comb begin
        timeout = active && !mem_ready && (count_q == CNT_W'(MEM_TIMEOUT));
        count_d = '0;
        if (active && !mem_ready && !timeout) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: steps fetch/decode/execute/memory/
// writeback and decodes every datapath select and strobe from the state.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_fsm_if.master bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   wait_active;
    logic   timeout;

    assign wait_active = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);

    mem_wait_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .active   (wait_active),
        .mem_ready(bus.mem_ready),
        .timeout  (timeout)
    );

    // State register; reset always returns to instruction fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; reset masks every strobe immediately.
    always_comb begin
        state_d = FETCH;
        ctrl    = '0;
        case (state_q)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                if (timeout) begin
                    ctrl.mem_read    = 1'b0;
                    ctrl.mem_timeout = 1'b1;
                end else if (bus.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = DECODE;
                end
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      ctrl.illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
                if (timeout) begin
                    ctrl.mem_read    = 1'b0;
                    ctrl.mem_timeout = 1'b1;
                end else if (bus.mem_ready) begin
                    state_d = MEMWB;
                end else begin
                    state_d = MEMRD;
                end
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                if (timeout) begin
                    ctrl.mem_write   = 1'b0;
                    ctrl.mem_timeout = 1'b1;
                end else if (bus.mem_ready) begin
                    ctrl.instr_done = 1'b1;
                end else begin
                    state_d = MEMWR;
                end
            end
            EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = ALUWB;
            end
            ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_src     = PC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = ADDIWB;
            end
            ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            JUMP: begin
                ctrl.pc_src     = PC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        if (reset) begin
            ctrl = '0;
        end
    end

    assign bus.pc_write    = ctrl.pc_write;
    assign bus.branch      = ctrl.branch;
    assign bus.ir_write    = ctrl.ir_write;
    assign bus.iord        = ctrl.iord;
    assign bus.mem_read    = ctrl.mem_read;
    assign bus.mem_write   = ctrl.mem_write;
    assign bus.reg_dst     = ctrl.reg_dst;
    assign bus.mem_to_reg  = ctrl.mem_to_reg;
    assign bus.reg_write   = ctrl.reg_write;
    assign bus.alu_src_a   = ctrl.alu_src_a;
    assign bus.alu_src_b   = ctrl.alu_src_b;
    assign bus.alu_op      = ctrl.alu_op;
    assign bus.pc_src      = ctrl.pc_src;
    assign bus.instr_done  = ctrl.instr_done;
    assign bus.illegal_op  = ctrl.illegal_op;
    assign bus.mem_timeout = ctrl.mem_timeout;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for the multicycle control sequencer: a table of
// instructions with zero-wait memory, then hand-built reset, illegal-opcode,
// memory-wait and watchdog sequences.
module tb_multicycle_control_fsm;
    import mc_ctrl_pkg::*;

    typedef struct {
        string           name;
        logic [5:0]      op;
        int              cycles;
        logic [0:4][3:0] seq;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset;
    ctrl_t act;
    int    tests_run = 0;
    int    tests_failed = 0;
    int    sb_q[$];
    vec_t  vecs[6];
    logic [3:0] lw_st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    logic       lw_rdy[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(
        .MEM_TIMEOUT(15),
        .CNT_W      (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Gather the DUT outputs into one record for whole-vector comparison.
    always_comb begin
        act             = '0;
        act.pc_write    = bus.pc_write;
        act.branch      = bus.branch;
        act.ir_write    = bus.ir_write;
        act.iord        = bus.iord;
        act.mem_read    = bus.mem_read;
        act.mem_write   = bus.mem_write;
        act.reg_dst     = bus.reg_dst;
        act.mem_to_reg  = bus.mem_to_reg;
        act.reg_write   = bus.reg_write;
        act.alu_src_a   = bus.alu_src_a;
        act.alu_src_b   = src_b_t'(bus.alu_src_b);
        act.alu_op      = alu_op_t'(bus.alu_op);
        act.pc_src      = pc_src_t'(bus.pc_src);
        act.instr_done  = bus.instr_done;
        act.illegal_op  = bus.illegal_op;
        act.mem_timeout = bus.mem_timeout;
    end

    // Reference decode of the required outputs for a given state and ready level.
    function automatic ctrl_t exp_outs(input logic [3:0] st, input logic ready, input logic [5:0] op);
        ctrl_t e;
        e = '0;
        case (st)
            4'd0: begin
                e.mem_read  = 1'b1;
                e.alu_src_b = src_b_t'(2'b01);
                if (ready) begin
                    e.ir_write = 1'b1;
                    e.pc_write = 1'b1;
                end
            end
            4'd1: begin
                e.alu_src_b = src_b_t'(2'b11);
                if (!(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010}))
                    e.illegal_op = 1'b1;
            end
            4'd2: begin
                e.alu_src_a = 1'b1;
                e.alu_src_b = src_b_t'(2'b10);
            end
            4'd3: begin
                e.iord     = 1'b1;
                e.mem_read = 1'b1;
            end
            4'd4: begin
                e.reg_write  = 1'b1;
                e.mem_to_reg = 1'b1;
                e.instr_done = 1'b1;
            end
            4'd5: begin
                e.iord       = 1'b1;
                e.mem_write  = 1'b1;
                e.instr_done = ready;
            end
            4'd6: begin
                e.alu_src_a = 1'b1;
                e.alu_op    = alu_op_t'(2'b10);
            end
            4'd7: begin
                e.reg_write  = 1'b1;
                e.reg_dst    = 1'b1;
                e.instr_done = 1'b1;
            end
            4'd8: begin
                e.alu_src_a  = 1'b1;
                e.alu_op     = alu_op_t'(2'b01);
                e.pc_src     = pc_src_t'(2'b01);
                e.branch     = 1'b1;
                e.instr_done = 1'b1;
            end
            4'd9: begin
                e.alu_src_a = 1'b1;
                e.alu_src_b = src_b_t'(2'b10);
            end
            4'd10: begin
                e.reg_write  = 1'b1;
                e.instr_done = 1'b1;
            end
            4'd11: begin
                e.pc_src     = pc_src_t'(2'b10);
                e.pc_write   = 1'b1;
                e.instr_done = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic applyStimulus(input logic ready, input logic [5:0] op);
        bus.mem_ready = ready;
        bus.opcode    = op;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp_state, input ctrl_t exp);
        tests_run++;
        if (bus.state !== exp_state) begin
            tests_failed++;
            $display("[TB] FAIL %s state: got %0d expected %0d", name, bus.state, exp_state);
        end
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s outputs: got %b expected %b", name, act, exp);
        end
    endtask

    // One clock: drive inputs just after a rising edge, check at the falling edge.
    task automatic do_cycle(input string name, input logic ready, input logic [5:0] op,
                            input logic [3:0] exp_state, input ctrl_t exp, output logic done_seen);
        applyStimulus(ready, op);
        @(negedge clk);
        checkOutput(name, exp_state, exp);
        done_seen = bus.instr_done;
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string name, input int got);
        int want;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s latency: got %0d expected none pending", name, got);
        end else begin
            want = sb_q.pop_front();
            if (got != want) begin
                tests_failed++;
                $display("[TB] FAIL %s latency: got %0d expected %0d", name, got, want);
            end
        end
    endtask

    // Hard stop in case something upstream stops the clock-driven flow.
    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic seen;
        ctrl_t e;
        int ir_pulses;

        vecs[0] = '{name: "rtype", op: 6'b000000, cycles: 4, seq: {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}};
        vecs[1] = '{name: "lw",    op: 6'b100011, cycles: 5, seq: {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}};
        vecs[2] = '{name: "sw",    op: 6'b101011, cycles: 4, seq: {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}};
        vecs[3] = '{name: "beq",   op: 6'b000100, cycles: 3, seq: {4'd0, 4'd1, 4'd8, 4'd0, 4'd0}};
        vecs[4] = '{name: "addi",  op: 6'b001000, cycles: 4, seq: {4'd0, 4'd1, 4'd9, 4'd10, 4'd0}};
        vecs[5] = '{name: "j",     op: 6'b000010, cycles: 3, seq: {4'd0, 4'd1, 4'd11, 4'd0, 4'd0}};

        reset    = 1'b1;
        bus.zero = 1'b0;
        applyStimulus(1'b0, 6'b000000);
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset_init", 4'd0, '0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_cycle("release_fetch", 1'b0, 6'b000000, 4'd0, exp_outs(4'd0, 1'b0, 6'b000000), seen);

        for (int v = 0; v < 6; v++) begin
            int  cyc;
            logic done;
            cyc  = 0;
            done = 1'b0;
            sb_q.push_back(vecs[v].cycles);
            while (!done && cyc < 10) begin
                applyStimulus(1'b1, vecs[v].op);
                bus.zero = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (cyc < vecs[v].cycles)
                    checkOutput(vecs[v].name, vecs[v].seq[cyc], exp_outs(vecs[v].seq[cyc], 1'b1, vecs[v].op));
                cyc++;
                if (bus.instr_done === 1'b1) begin
                    done = 1'b1;
                    sb_check(vecs[v].name, cyc);
                end
                @(posedge clk);
                #1;
            end
            if (!done) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL %s instr_done: got none expected pulse", vecs[v].name);
                if (sb_q.size() > 0) void'(sb_q.pop_front());
            end
        end

        do_cycle("rst_fetch", 1'b1, 6'b000000, 4'd0, exp_outs(4'd0, 1'b1, 6'b000000), seen);
        do_cycle("rst_decode", 1'b1, 6'b000000, 4'd1, exp_outs(4'd1, 1'b1, 6'b000000), seen);
        applyStimulus(1'b1, 6'b000000);
        @(negedge clk);
        checkOutput("rst_execute", 4'd6, exp_outs(4'd6, 1'b1, 6'b000000));
        reset = 1'b1;
        #1;
        checkOutput("reset_async", 4'd0, '0);
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("reset_hold", 4'd0, '0);
        end
        reset = 1'b0;
        do_cycle("after_reset", 1'b0, 6'b000000, 4'd0, exp_outs(4'd0, 1'b0, 6'b000000), seen);

        do_cycle("ill_fetch", 1'b1, 6'b111111, 4'd0, exp_outs(4'd0, 1'b1, 6'b111111), seen);
        do_cycle("ill_decode", 1'b1, 6'b111111, 4'd1, exp_outs(4'd1, 1'b1, 6'b111111), seen);
        do_cycle("ill_next", 1'b0, 6'b111111, 4'd0, exp_outs(4'd0, 1'b0, 6'b111111), seen);

        sb_q.push_back(8);
        for (int i = 0; i < 8; i++) begin
            do_cycle("lw_wait", lw_rdy[i], 6'b100011, lw_st[i], exp_outs(lw_st[i], lw_rdy[i], 6'b100011), seen);
            if (seen === 1'b1) sb_check("lw_wait", i + 1);
        end

        do_cycle("swto_fetch", 1'b1, 6'b101011, 4'd0, exp_outs(4'd0, 1'b1, 6'b101011), seen);
        do_cycle("swto_decode", 1'b1, 6'b101011, 4'd1, exp_outs(4'd1, 1'b1, 6'b101011), seen);
        do_cycle("swto_memadr", 1'b1, 6'b101011, 4'd2, exp_outs(4'd2, 1'b1, 6'b101011), seen);
        for (int i = 1; i <= 16; i++) begin
            e = exp_outs(4'd5, 1'b0, 6'b101011);
            if (i == 16) begin
                e.mem_write   = 1'b0;
                e.mem_timeout = 1'b1;
            end
            do_cycle("swto_memwr", 1'b0, 6'b101011, 4'd5, e, seen);
        end

        ir_pulses = 0;
        for (int i = 1; i <= 21; i++) begin
            logic rdy;
            rdy = (i == 21);
            e = exp_outs(4'd0, rdy, 6'b101011);
            if (i == 16) begin
                e.mem_read    = 1'b0;
                e.mem_timeout = 1'b1;
            end
            applyStimulus(rdy, 6'b101011);
            @(negedge clk);
            checkOutput("fetch_retry", 4'd0, e);
            if (bus.ir_write === 1'b1) ir_pulses++;
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (ir_pulses != 1) begin
            tests_failed++;
            $display("[TB] FAIL fetch_ir_pulses: got %0d expected 1", ir_pulses);
        end
        do_cycle("retry_decode", 1'b1, 6'b101011, 4'd1, exp_outs(4'd1, 1'b1, 6'b101011), seen);

        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
